// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic {IDLE, RUN} state_e;

   function automatic int steps_f(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_w_f(input int width, input int digit);
      return $clog2(width / digit + 1);
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple of DIGIT full adders; also exposes the carry into the top bit.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             cin_i,
   output logic [DIGIT-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   logic carry;

   always_comb begin
      carry  = cin_i;
      sum_o  = '0;
      cmsb_o = cin_i;
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) cmsb_o = carry;
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, DIGIT bits per clock; Done pulses WIDTH/DIGIT edges after accept.
// Start is only accepted while idle (including the Done cycle); requests while busy are dropped.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int STEPS = steps_f(WIDTH, DIGIT);
   localparam int CW    = cnt_w_f(WIDTH, DIGIT);

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
   end

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

   logic [DIGIT-1:0]  dig_sum;
   logic              dig_cout, dig_cmsb;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a_i    (a_q[DIGIT-1:0]),
      .b_i    (b_q[DIGIT-1:0]),
      .cin_i  (carry_q),
      .sum_o  (dig_sum),
      .cout_o (dig_cout),
      .cmsb_o (dig_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // Subtraction is A + ~B + 1: invert B once here and seed the carry.
            if (start_i) begin
               state_d = RUN;
               a_d     = a_i;
               b_d     = b_i ^ {WIDTH{sub_i}};
               carry_d = sub_i;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
            carry_d = dig_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               state_d = IDLE;
               cout_d  = dig_cout;
               ovf_d   = dig_cout ^ dig_cmsb;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = done_q;
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Checks three serial_addsub instances (DIGIT 4, 16, 1) against an arithmetic reference.
module tb_serial_addsub;

   localparam int W = 16;
   localparam int N = 3;
   localparam int DG [N] = '{4, 16, 1};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_s [N];
   logic         sub_s   [N];
   logic [W-1:0] a_s     [N];
   logic [W-1:0] b_s     [N];
   logic         busy_s  [N];
   logic         done_s  [N];
   logic [W-1:0] sum_s   [N];
   logic         cout_s  [N];
   logic         ovf_s   [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      serial_addsub #(.WIDTH(W), .DIGIT(DG[g])) u_dut (
         .clk_i   (clk),
         .rst_n_i (rst_n),
         .start_i (start_s[g]),
         .sub_i   (sub_s[g]),
         .a_i     (a_s[g]),
         .b_i     (b_s[g]),
         .busy_o  (busy_s[g]),
         .done_o  (done_s[g]),
         .sum_o   (sum_s[g]),
         .cout_o  (cout_s[g]),
         .ovf_o   (ovf_s[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: integer arithmetic on the operand values.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic c, output logic o);
      int sa;
      int sb;
      int r;
      int ua;
      int ub;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      r  = sub ? sa - sb : sa + sb;
      o  = (r > 32767) || (r < -32768);
      if (sub) begin
         s = a - b;
         c = (ua >= ub);
      end else begin
         s = a + b;
         c = (ua + ub) > 65535;
      end
   endtask

   task automatic launch(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      @(negedge clk);
      start_s[k] = 1'b1;
      a_s[k]     = a;
      b_s[k]     = b;
      sub_s[k]   = sub;
      @(posedge clk);
      #1;
      start_s[k] = 1'b0;
      a_s[k]     = 16'($urandom);
      b_s[k]     = 16'($urandom);
      sub_s[k]   = 1'($urandom);
   endtask

   task automatic wait_done(input int k, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!done_s[k] && lat < 200);
   endtask

   task automatic check_result(input string tag, input int k,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
      model(a, b, sub, es, ec, eo);
      check($sformatf("%s k%0d done", tag, k), 32'(done_s[k]), 32'(1));
      check($sformatf("%s k%0d sum", tag, k), 32'(sum_s[k]), 32'(es));
      check($sformatf("%s k%0d cout", tag, k), 32'(cout_s[k]), 32'(ec));
      check($sformatf("%s k%0d ovf", tag, k), 32'(ovf_s[k]), 32'(eo));
      check($sformatf("%s k%0d busy", tag, k), 32'(busy_s[k]), 32'(0));
   endtask

   task automatic do_op(input string tag, input int k,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int lat;
      launch(k, a, b, sub);
      wait_done(k, lat);
      check($sformatf("%s k%0d lat", tag, k), 32'(lat), 32'(W / DG[k]));
      check_result(tag, k, a, b, sub);
      @(negedge clk);
      check($sformatf("%s k%0d pulse", tag, k), 32'(done_s[k]), 32'(0));
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
   } vec_t;

   vec_t dir [5] = '{
      '{16'h1234, 16'h0FF0, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0},
      '{16'h0005, 16'h0007, 1'b1},
      '{16'h8000, 16'h0001, 1'b1}
   };

   initial begin
      int lat;
      logic saw_done;
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         start_s[k] = 1'b0;
         sub_s[k]   = 1'b0;
         a_s[k]     = '0;
         b_s[k]     = '0;
      end
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("rst k%0d busy", k), 32'(busy_s[k]), 32'(0));
         check($sformatf("rst k%0d done", k), 32'(done_s[k]), 32'(0));
         check($sformatf("rst k%0d sum", k), 32'(sum_s[k]), 32'(0));
         check($sformatf("rst k%0d flags", k), 32'({cout_s[k], ovf_s[k]}), 32'(0));
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < N; k++)
         for (int i = 0; i < 5; i++)
            do_op($sformatf("dir%0d", i), k, dir[i].a, dir[i].b, dir[i].sub);

      for (int k = 0; k < N; k++)
         for (int i = 0; i < 15; i++)
            do_op($sformatf("rnd%0d", i), k, 16'($urandom), 16'($urandom), 1'($urandom));

      // Start re-pulsed while busy must not disturb the running operation.
      launch(0, 16'h1234, 16'h0FF0, 1'b0);
      @(posedge clk);
      #1;
      start_s[0] = 1'b1;
      a_s[0]     = 16'hFFFF;
      b_s[0]     = 16'hFFFF;
      sub_s[0]   = 1'b1;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      wait_done(0, lat);
      check("busy_restart lat", 32'(lat + 2), 32'(4));
      check_result("busy_restart", 0, 16'h1234, 16'h0FF0, 1'b0);

      // Back-to-back: Start held in the Done cycle.
      start_s[0] = 1'b1;
      a_s[0]     = 16'h7FFF;
      b_s[0]     = 16'h0001;
      sub_s[0]   = 1'b0;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      wait_done(0, lat);
      check("b2b lat", 32'(lat), 32'(4));
      check_result("b2b", 0, 16'h7FFF, 16'h0001, 1'b0);

      // Asynchronous reset in the middle of RUN.
      launch(0, 16'h1234, 16'h0FF0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy_s[0]), 32'(0));
      check("midrst done", 32'(done_s[0]), 32'(0));
      check("midrst sum", 32'(sum_s[0]), 32'(0));
      check("midrst flags", 32'({cout_s[0], ovf_s[0]}), 32'(0));
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done_s[0]) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done_s[0] || busy_s[0]) saw_done = 1'b1;
      end
      check("midrst no_done", 32'(saw_done), 32'(0));
      do_op("post_rst", 0, 16'h1234, 16'h0FF0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
